// File: rtl/ins_pkg.sv
// Shared constants, command payload and encode/reject helpers for the instruction encoder-loader.
package ins_pkg;

  localparam int unsigned OP_W   = 6;
  localparam int unsigned WORD_W = 32;

  localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
  localparam logic [OP_W-1:0] OP_ANDI  = 6'b001100;
  localparam logic [OP_W-1:0] OP_XORI  = 6'b001110;
  localparam logic [OP_W-1:0] OP_SLTIU = 6'b001011;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OP_W-1:0] OP_BNE   = 6'b000101;
  localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
  localparam logic [OP_W-1:0] OP_NOP   = 6'b111111;

  localparam logic [2:0] KIND_ALUR   = 3'd0;
  localparam logic [2:0] KIND_ALUI   = 3'd1;
  localparam logic [2:0] KIND_LOAD   = 3'd2;
  localparam logic [2:0] KIND_STORE  = 3'd3;
  localparam logic [2:0] KIND_BRANCH = 3'd4;
  localparam logic [2:0] KIND_NOP    = 3'd5;

  localparam logic [WORD_W-1:0] NOP_WORD = {OP_NOP, 26'd0};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAD   = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  typedef struct packed {
    logic [2:0]  kind;
    logic [1:0]  sel;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [5:0]  funct;
    logic [15:0] imm;
  } ins_cmd_t;

  // Commands the analyser could not map back to a class are dropped.
  function automatic logic is_reject(input ins_cmd_t c);
    logic r;
    r = 1'b0;
    if (c.kind > KIND_NOP) r = 1'b1;
    if (c.kind == KIND_BRANCH && c.sel[1]) r = 1'b1;
    if (c.kind == KIND_ALUR && c.funct == 6'd0) r = 1'b1;
    return r;
  endfunction

  function automatic logic [WORD_W-1:0] encode(input ins_cmd_t c);
    logic [WORD_W-1:0] w;
    logic [OP_W-1:0]   op;
    w  = NOP_WORD;
    op = OP_ADDI;
    case (c.sel)
      2'd0:    op = OP_ADDI;
      2'd1:    op = OP_ANDI;
      2'd2:    op = OP_XORI;
      default: op = OP_SLTIU;
    endcase
    case (c.kind)
      KIND_ALUR:   w = {OP_RTYPE, c.rs, c.rt, c.rd, c.shamt, c.funct};
      KIND_ALUI:   w = {op, c.rs, c.rt, c.imm};
      KIND_LOAD:   w = {OP_LW, c.rs, c.rt, c.imm};
      KIND_STORE:  w = {OP_SW, c.rs, c.rt, c.imm};
      KIND_BRANCH: w = {(c.sel[0] ? OP_BNE : OP_BEQ), c.rs, c.rt, c.imm};
      default:     w = NOP_WORD;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/ins_fifo.sv
// Synchronous FIFO with occupancy count; push into a full FIFO is allowed when popping in the same cycle.
module ins_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 42
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop && (count != '0);
  assign do_push = push && ((count != CNT_W'(DEPTH)) || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (do_push && !do_pop)      count <= count + CNT_W'(1);
      else if (do_pop && !do_push) count <= count - CNT_W'(1);
    end
  end

  // Storage carries no reset; occupancy alone qualifies the contents.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/ins_encoder_loader.sv
// Encodes instruction-class commands into IR words and streams them into instruction memory,
// padding the program tail with NOPs to an aligned boundary.
module ins_encoder_loader import ins_pkg::*; #(
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned ADDR_W     = 10,
  parameter int unsigned ALIGN_LOG2 = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_kind,
  input  logic [1:0]        cmd_sel,
  input  logic [4:0]        cmd_rs,
  input  logic [4:0]        cmd_rt,
  input  logic [4:0]        cmd_rd,
  input  logic [4:0]        cmd_shamt,
  input  logic [5:0]        cmd_funct,
  input  logic [15:0]       cmd_imm,
  input  logic              cmd_last,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  input  logic              imem_ready,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   words_written
);

  localparam int unsigned ENTRY_W = ADDR_W + WORD_W;
  localparam int unsigned CNT_W   = $clog2(DEPTH) + 1;
  localparam int unsigned WW_W    = ADDR_W + 1;
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'((1 << ALIGN_LOG2) - 1);
  localparam logic [WW_W-1:0]   WW_MAX     = {1'b1, {ADDR_W{1'b0}}};

  state_t              state_q, state_d;
  ins_cmd_t            cmd;
  logic                stage_valid_q;
  logic [ENTRY_W-1:0]  stage_q;
  logic [ADDR_W-1:0]   push_addr_q;
  logic [CNT_W-1:0]    fifo_count;
  logic [ENTRY_W-1:0]  fifo_head;
  logic                accept, rejected, enc_load, pad_load, stage_load;
  logic                aligned, space, pop, start_ok;
  int                  occ_nxt;
  logic                cmd_ready_d, busy_d, done_d, err_d;
  logic [WW_W-1:0]     words_written_d;

  always_comb begin
    cmd.kind  = cmd_kind;
    cmd.sel   = cmd_sel;
    cmd.rs    = cmd_rs;
    cmd.rt    = cmd_rt;
    cmd.rd    = cmd_rd;
    cmd.shamt = cmd_shamt;
    cmd.funct = cmd_funct;
    cmd.imm   = cmd_imm;
  end

  assign start_ok   = start && (state_q == ST_IDLE);
  assign accept     = cmd_valid && cmd_ready && (state_q == ST_RUN);
  assign rejected   = accept && is_reject(cmd);
  assign enc_load   = accept && !rejected;
  assign aligned    = (push_addr_q & ALIGN_MASK) == '0;
  assign space      = (int'(fifo_count) + int'(stage_valid_q)) < int'(DEPTH);
  assign pad_load   = (state_q == ST_PAD) && !aligned && space;
  assign stage_load = enc_load || pad_load;
  assign imem_we    = (fifo_count != '0);
  assign pop        = imem_we && imem_ready;
  assign imem_addr  = imem_we ? fifo_head[ENTRY_W-1:WORD_W] : '0;
  assign imem_wdata = imem_we ? fifo_head[WORD_W-1:0] : '0;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start) state_d = ST_RUN;
      ST_RUN:   if (accept && cmd_last) state_d = ST_PAD;
      ST_PAD:   if (aligned) state_d = ST_DRAIN;
      ST_DRAIN: if (!stage_valid_q && (fifo_count == '0)) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Output logic; cmd_ready looks one cycle ahead so it can be registered
  always_comb begin
    occ_nxt         = int'(fifo_count) + int'(stage_valid_q) - int'(pop) + int'(stage_load);
    cmd_ready_d     = (state_d == ST_RUN) && (occ_nxt < int'(DEPTH));
    busy_d          = (state_d != ST_IDLE);
    done_d          = (state_q == ST_DRAIN) && (state_d == ST_IDLE);
    err_d           = err;
    words_written_d = words_written;
    if (start_ok) begin
      err_d           = 1'b0;
      words_written_d = '0;
    end else begin
      if (rejected) err_d = 1'b1;
      if (pop && (words_written != WW_MAX)) words_written_d = words_written + WW_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_ready     <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      err           <= 1'b0;
      words_written <= '0;
    end else begin
      cmd_ready     <= cmd_ready_d;
      busy          <= busy_d;
      done          <= done_d;
      err           <= err_d;
      words_written <= words_written_d;
    end
  end

  // Encode stage and push address; the stage always drains into the FIFO next cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_valid_q <= 1'b0;
      stage_q       <= '0;
      push_addr_q   <= '0;
    end else begin
      stage_valid_q <= stage_load;
      if (enc_load)      stage_q <= {push_addr_q, encode(cmd)};
      else if (pad_load) stage_q <= {push_addr_q, NOP_WORD};
      if (start_ok)        push_addr_q <= base_addr;
      else if (stage_load) push_addr_q <= push_addr_q + ADDR_W'(1);
    end
  end

  ins_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (stage_valid_q),
    .push_data (stage_q),
    .pop       (pop),
    .head      (fifo_head),
    .count     (fifo_count)
  );

endmodule

// File: tb/tb_ins_encoder_loader.sv
// Directed bench for ins_encoder_loader: encodings, padding/wrap, backpressure, rejects, reset abort.
module tb_ins_encoder_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [9:0]  base_addr;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_kind;
  logic [1:0]  cmd_sel;
  logic [4:0]  cmd_rs, cmd_rt, cmd_rd, cmd_shamt;
  logic [5:0]  cmd_funct;
  logic [15:0] cmd_imm;
  logic        cmd_last;
  logic        imem_we;
  logic [9:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic        imem_ready;
  logic        busy, done, err;
  logic [10:0] words_written;

  int n_checks = 0;
  int n_pass   = 0;
  int done_cnt = 0;
  logic [9:0]  wa[$];
  logic [31:0] wd[$];

  localparam logic [31:0] NOP = 32'hFC00_0000;

  ins_encoder_loader dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_kind(cmd_kind), .cmd_sel(cmd_sel),
    .cmd_rs(cmd_rs), .cmd_rt(cmd_rt), .cmd_rd(cmd_rd), .cmd_shamt(cmd_shamt),
    .cmd_funct(cmd_funct), .cmd_imm(cmd_imm), .cmd_last(cmd_last),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata), .imem_ready(imem_ready),
    .busy(busy), .done(done), .err(err), .words_written(words_written)
  );

  always #5 clk = ~clk;

  // Write/done logger, sampled mid-cycle after inputs settle
  always begin
    @(negedge clk);
    #2;
    if (rst_n && imem_we && imem_ready) begin
      wa.push_back(imem_addr);
      wd.push_back(imem_wdata);
    end
    if (rst_n && done) done_cnt++;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic clear_log();
    wa.delete();
    wd.delete();
    done_cnt = 0;
  endtask

  task automatic check_write(input string tag, input int idx, input logic [9:0] ea, input logic [31:0] ed);
    if (idx < wa.size()) begin
      check({tag, "_addr"}, 64'(wa[idx]), 64'(ea));
      check({tag, "_data"}, 64'(wd[idx]), 64'(ed));
    end else begin
      check({tag, "_missing"}, 64'(wa.size()), 64'(idx + 1));
    end
  endtask

  task automatic do_start(input logic [9:0] base);
    @(negedge clk);
    start = 1'b1;
    base_addr = base;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic set_cmd(input logic [2:0] k, input logic [1:0] s, input logic [4:0] rs,
                         input logic [4:0] rt, input logic [4:0] rd, input logic [4:0] sh,
                         input logic [5:0] fn, input logic [15:0] imm, input logic last);
    cmd_kind = k; cmd_sel = s; cmd_rs = rs; cmd_rt = rt; cmd_rd = rd;
    cmd_shamt = sh; cmd_funct = fn; cmd_imm = imm; cmd_last = last;
  endtask

  task automatic send(input logic [2:0] k, input logic [1:0] s, input logic [4:0] rs,
                      input logic [4:0] rt, input logic [4:0] rd, input logic [4:0] sh,
                      input logic [5:0] fn, input logic [15:0] imm, input logic last);
    int n;
    @(negedge clk);
    set_cmd(k, s, rs, rt, rd, sh, fn, imm, last);
    cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) check("send_timeout", 64'(cmd_ready), 64'(1));
    else @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    @(negedge clk);
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_idle"}, 64'(busy), 64'(0));
    @(negedge clk);
    #3;
  endtask

  initial begin
    int acc;
    int n;
    rst_n = 1'b0; start = 1'b0; base_addr = '0; cmd_valid = 1'b0; imem_ready = 1'b1;
    set_cmd(3'd0, 2'd0, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 1'b0);

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_outputs", 64'({cmd_ready, imem_we, busy, done, err}), 64'(0));
    check("rst_addr_data", 64'({imem_addr, imem_wdata}), 64'(0));
    check("rst_words", 64'(words_written), 64'(0));
    rst_n = 1'b1;

    // ALUR encode with tail padding
    clear_log();
    do_start(10'h010);
    check("start_busy", 64'(busy), 64'(1));
    send(3'd0, 2'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20, 16'd0, 1'b1);
    wait_idle("alur");
    check("alur_nwr", 64'(wa.size()), 64'(4));
    check_write("alur_w0", 0, 10'h010, 32'h0022_1820);
    check_write("alur_p1", 1, 10'h011, NOP);
    check_write("alur_p2", 2, 10'h012, NOP);
    check_write("alur_p3", 3, 10'h013, NOP);
    check("alur_done", 64'(done_cnt), 64'(1));
    check("alur_words", 64'(words_written), 64'(4));

    // I-type encodings, four words from an aligned base: no padding
    clear_log();
    do_start(10'h020);
    send(3'd1, 2'd0, 5'd0, 5'd5, 5'd0, 5'd0, 6'd0, 16'hFFFF, 1'b0);
    send(3'd4, 2'd0, 5'd1, 5'd2, 5'd0, 5'd0, 6'd0, 16'h0003, 1'b0);
    send(3'd4, 2'd1, 5'd1, 5'd2, 5'd0, 5'd0, 6'd0, 16'h0003, 1'b0);
    send(3'd2, 2'd0, 5'd4, 5'd6, 5'd0, 5'd0, 6'd0, 16'h0008, 1'b1);
    wait_idle("ityp");
    check("ityp_nwr", 64'(wa.size()), 64'(4));
    check_write("addi", 0, 10'h020, 32'h2005_FFFF);
    check_write("beq",  1, 10'h021, 32'h1022_0003);
    check_write("bne",  2, 10'h022, 32'h1422_0003);
    check_write("lw",   3, 10'h023, 32'h8C86_0008);

    // Base 0x004, exactly four commands: no pad words
    clear_log();
    do_start(10'h004);
    send(3'd1, 2'd1, 5'd1, 5'd1, 5'd0, 5'd0, 6'd0, 16'h00F0, 1'b0);
    send(3'd1, 2'd3, 5'd2, 5'd3, 5'd0, 5'd0, 6'd0, 16'h0001, 1'b0);
    send(3'd5, 2'd0, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'h0000, 1'b0);
    send(3'd3, 2'd0, 5'd4, 5'd6, 5'd0, 5'd0, 6'd0, 16'h0008, 1'b1);
    wait_idle("algn");
    check("algn_nwr", 64'(wa.size()), 64'(4));
    check("algn_words", 64'(words_written), 64'(4));
    check_write("andi",  0, 10'h004, 32'h3021_00F0);
    check_write("sltiu", 1, 10'h005, 32'h2C43_0001);
    check_write("nop",   2, 10'h006, NOP);
    check_write("sw",    3, 10'h007, 32'hAC86_0008);

    // Address wrap at 0x3FF then pad to 0x003
    clear_log();
    do_start(10'h3FF);
    send(3'd0, 2'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'h21, 16'd0, 1'b0);
    send(3'd1, 2'd2, 5'd2, 5'd3, 5'd0, 5'd0, 6'd0, 16'h00FF, 1'b1);
    wait_idle("wrap");
    check("wrap_nwr", 64'(wa.size()), 64'(5));
    check_write("wrap_w0", 0, 10'h3FF, 32'h0022_1821);
    check_write("wrap_w1", 1, 10'h000, 32'h3843_00FF);
    check_write("wrap_p1", 2, 10'h001, NOP);
    check_write("wrap_p3", 4, 10'h003, NOP);
    check("wrap_done", 64'(done_cnt), 64'(1));

    // Backpressure: memory stalled for 20 cycles
    clear_log();
    imem_ready = 1'b0;
    do_start(10'h100);
    acc = 0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      @(negedge clk);
      set_cmd(3'd0, 2'd0, 5'd1, 5'd2, 5'(acc), 5'd0, 6'h20, 16'd0, 1'b0);
      cmd_valid = 1'b1;
      if (cyc == 10) check("bp_hold_mid", 64'({imem_addr, imem_wdata}), {22'd0, 10'h100, 32'h0022_0020});
      if (cmd_ready) acc++;
    end
    @(negedge clk);
    check("bp_accepted", 64'(acc), 64'(4));
    check("bp_ready_low", 64'(cmd_ready), 64'(0));
    check("bp_we", 64'(imem_we), 64'(1));
    check("bp_hold_end", 64'({imem_addr, imem_wdata}), {22'd0, 10'h100, 32'h0022_0020});
    imem_ready = 1'b1;
    n = 0;
    while (acc < 6 && n < 100) begin
      if (n > 0) @(negedge clk);
      set_cmd(3'd0, 2'd0, 5'd1, 5'd2, 5'(acc), 5'd0, 6'h20, 16'd0, acc == 5);
      cmd_valid = 1'b1;
      if (cmd_ready) acc++;
      n++;
    end
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    wait_idle("bp");
    check("bp_nwr", 64'(wa.size()), 64'(8));
    for (int i = 0; i < 8; i++)
      check_write("bp_w", i, 10'h100 + 10'(i), (i < 6) ? (32'h0022_0020 | (32'(i) << 11)) : NOP);
    check("bp_words", 64'(words_written), 64'(8));

    // Rejected commands: err set, nothing written, address not advanced
    clear_log();
    do_start(10'h200);
    send(3'd6, 2'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20, 16'd0, 1'b0);
    send(3'd0, 2'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'h00, 16'd0, 1'b0);
    send(3'd4, 2'd2, 5'd1, 5'd2, 5'd0, 5'd0, 6'd0, 16'h0003, 1'b0);
    repeat (4) @(negedge clk);
    check("rej_err", 64'(err), 64'(1));
    check("rej_nwr", 64'(wa.size()), 64'(0));
    check("rej_we", 64'(imem_we), 64'(0));
    send(3'd1, 2'd0, 5'd0, 5'd5, 5'd0, 5'd0, 6'd0, 16'hFFFF, 1'b1);
    wait_idle("rej");
    check_write("rej_next", 0, 10'h200, 32'h2005_FFFF);
    check("rej_err_sticky", 64'(err), 64'(1));
    do_start(10'h040);
    check("start_clr_err", 64'(err), 64'(0));
    send(3'd5, 2'd0, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 1'b1);
    wait_idle("rej2");
    check("rej2_words", 64'(words_written), 64'(4));

    // Reset mid-run with three words queued
    imem_ready = 1'b0;
    do_start(10'h300);
    for (int i = 0; i < 3; i++)
      send(3'd0, 2'd0, 5'd1, 5'd2, 5'(i), 5'd0, 6'h20, 16'd0, 1'b0);
    repeat (3) @(negedge clk);
    check("mid_we", 64'(imem_we), 64'(1));
    rst_n = 1'b0;
    #1;
    check("mid_rst_flags", 64'({cmd_ready, imem_we, busy, done, err}), 64'(0));
    check("mid_rst_addr_data", 64'({imem_addr, imem_wdata}), 64'(0));
    check("mid_rst_words", 64'(words_written), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    imem_ready = 1'b1;
    clear_log();
    repeat (10) @(negedge clk);
    check("post_busy", 64'(busy), 64'(0));
    check("post_nwr", 64'(wa.size()), 64'(0));
    check("post_done", 64'(done_cnt), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

endmodule
